exp10_seg7_scan: RTL and testbench

//   Downstream display stage for the 4-digit BCD counter. Snapshots the four BCD

---
 rtl/exp10_seg7_scan.sv | 154 +++++++++++++++
 tb/tb_exp10_seg7_scan.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/exp10_seg7_scan.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame snapshot and sticky overflow dp.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module exp10_seg7_scan #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] thousands,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       Cout,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam int unsigned    CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Prescaler and digit index
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             tick;
    logic [1:0]       idx_q, idx_d;
    logic             frame_end;

    // Frame snapshot
    logic [15:0]      snap_q, snap_d;
    logic             frame_done_q;

    // Overflow capture
    logic             cout_meta_q, cout_sync_q, cout_prev_q;
    logic             ovf_q, ovf_d;

    // Display pipeline (active-high form)
    logic [3:0]       cur_digit;
    logic             blank;
    logic [6:0]       seg_d, seg_q;
    logic [3:0]       an_d, an_q;
    logic             dp_d, dp_q;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        tick      = (presc_q == CNT_MAX);
        presc_d   = tick ? '0 : presc_q + CNT_ONE;
        idx_d     = tick ? idx_q + 2'd1 : idx_q;
        frame_end = tick && (idx_q == 2'd3);
        snap_d    = frame_end ? {thousands, hundreds, tens, ones} : snap_q;
    end

    // Edge detect on the synchronised carry; the flag stays set until CLR.
    always_comb begin
        ovf_d = ovf_q | (cout_sync_q & ~cout_prev_q);
    end

    always_comb begin
        cur_digit = 4'd0;
        unique case (idx_q)
            2'd0: cur_digit = snap_q[3:0];
            2'd1: cur_digit = snap_q[7:4];
            2'd2: cur_digit = snap_q[11:8];
            2'd3: cur_digit = snap_q[15:12];
            default: cur_digit = 4'd0;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        blank = 1'b0;
        unique case (idx_q)
            2'd3:    blank = (snap_q[15:12] == 4'd0);
            2'd2:    blank = (snap_q[15:8] == 8'd0);
            2'd1:    blank = (snap_q[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_d = blank ? 7'h00 : bcd_to_seg(cur_digit);
        an_d  = 4'b0001 << idx_q;
        dp_d  = (idx_q == 2'd3) && ovf_q;
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            presc_q      <= '0;
            idx_q        <= 2'd0;
            snap_q       <= 16'h0000;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            frame_done_q <= frame_end;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            cout_meta_q <= 1'b0;
            cout_sync_q <= 1'b0;
            cout_prev_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            cout_meta_q <= Cout;
            cout_sync_q <= cout_meta_q;
            cout_prev_q <= cout_sync_q;
            ovf_q       <= ovf_d;
        end
    end

    // Zero in these registers is the inactive level before polarity is applied.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            seg_q <= 7'h00;
            an_q  <= 4'b0000;
            dp_q  <= 1'b0;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign seg        = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dp         = SEG_ACTIVE_LOW ? ~dp_q : dp_q;
    assign an         = DIG_ACTIVE_LOW ? ~an_q : an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_exp10_seg7_scan.sv
// Self-checking bench for exp10_seg7_scan: cycle-level model plus literal spot checks.
// Runs with SCAN_DIV=4, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=1.
module tb_exp10_seg7_scan;

    localparam int unsigned SD = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ_SEG = 8'h00;
`else
    localparam logic [7:0] LZ_SEG = 8'h3F;
`endif

    logic       CLK = 1'b0;
    logic       CLR;
    logic [3:0] thousands, hundreds, tens, ones;
    logic       Cout;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_done;

    int pass_cnt = 0;
    int total    = 0;

    // Model state: cycles since reset release, captured frame, overflow flag
    int          cyc;
    logic [15:0] snap_m;
    logic        ovf_m;
    int          pend;
    logic        cout_last;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fd;

    exp10_seg7_scan #(
        .SCAN_DIV      (SD),
        .SEG_ACTIVE_LOW(1'b0),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .Cout      (Cout),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] disp(input logic [15:0] s, input int i);
        logic [3:0] d;
        d = s[i*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        if (i == 3 && s[15:12] == 4'd0) return 7'h00;
        if (i == 2 && s[15:8] == 8'd0) return 7'h00;
        if (i == 1 && s[15:4] == 12'd0) return 7'h00;
`endif
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        else
            pass_cnt++;
    endtask

    task automatic model_reset();
        cyc       = 0;
        snap_m    = 16'h0000;
        ovf_m     = 1'b0;
        pend      = 0;
        cout_last = 1'b0;
        exp_an    = 4'b1111;
        exp_seg   = 7'h00;
        exp_dp    = 1'b0;
        exp_fd    = 1'b0;
    endtask

    // One clock: model advances on the rising edge, DUT compared on the falling edge.
    task automatic step();
        int i;
        @(posedge CLK);
        if (!CLR) begin
            i       = (cyc / SD) % 4;
            exp_an  = ~(4'b0001 << i);
            exp_seg = disp(snap_m, i);
            exp_dp  = (i == 3) && ovf_m;
            exp_fd  = (cyc % (4 * SD)) == (4 * SD - 1);
            if (exp_fd) snap_m = {thousands, hundreds, tens, ones};
            // Carry seen on an edge becomes the sticky flag two edges later.
            if (pend > 0) begin
                pend--;
                if (pend == 0) ovf_m = 1'b1;
            end
            if (Cout && !cout_last && pend == 0 && !ovf_m) pend = 2;
            cout_last = Cout;
            cyc++;
        end
        @(negedge CLK);
        check("an", {4'h0, an}, {4'h0, exp_an});
        check("seg", {1'b0, seg}, {1'b0, exp_seg});
        check("dp", {7'h0, dp}, {7'h0, exp_dp});
        check("frame_done", {7'h0, frame_done}, {7'h0, exp_fd});
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] d);
        thousands = a;
        hundreds  = b;
        tens      = c;
        ones      = d;
    endtask

    initial begin
        CLR  = 1'b1;
        Cout = 1'b0;
        set_in(4'd1, 4'd2, 4'd3, 4'd4);
        model_reset();
        #2;
        check("reset_an", {4'h0, an}, 8'h0F);
        check("reset_seg", {1'b0, seg}, 8'h00);
        check("reset_dp", {7'h0, dp}, 8'h00);
        check("reset_fd", {7'h0, frame_done}, 8'h00);
        @(negedge CLK);
        CLR = 1'b0;

        // First frame shows the zero snapshot
        step();
        check("first_an", {4'h0, an}, 8'h0E);
        check("first_seg", {1'b0, seg}, 8'h3F);
        steps(15);
        check("frame_done_pulse", {7'h0, frame_done}, 8'h01);

        // Scan order for 1,2,3,4; inputs change mid-frame to 9999
        step();
        check("scan0_an", {4'h0, an}, 8'h0E);
        check("scan0_seg", {1'b0, seg}, 8'h66);
        steps(4);
        check("scan1_an", {4'h0, an}, 8'h0D);
        check("scan1_seg", {1'b0, seg}, 8'h4F);
        set_in(4'd9, 4'd9, 4'd9, 4'd9);
        steps(4);
        check("scan2_an", {4'h0, an}, 8'h0B);
        check("scan2_seg", {1'b0, seg}, 8'h5B);
        steps(4);
        check("scan3_an", {4'h0, an}, 8'h07);
        check("scan3_seg", {1'b0, seg}, 8'h06);
        steps(4);
        check("nines_seg", {1'b0, seg}, 8'h6F);

        // Non-BCD ones digit
        set_in(4'd5, 4'd6, 4'd7, 4'hA);
        steps(16);
        check("dash_an", {4'h0, an}, 8'h0E);
        check("dash_seg", {1'b0, seg}, 8'h40);
        steps(4);
        check("tens_seg", {1'b0, seg}, 8'h07);

        // One-cycle carry pulse sets the sticky overflow
        Cout = 1'b1;
        step();
        Cout = 1'b0;
        steps(7);
        check("ovf_an", {4'h0, an}, 8'h07);
        check("ovf_dp", {7'h0, dp}, 8'h01);
        steps(4);
        check("ovf_dp_off_slot0", {7'h0, dp}, 8'h00);
        steps(12);
        check("ovf_persist_an", {4'h0, an}, 8'h07);
        check("ovf_persist_dp", {7'h0, dp}, 8'h01);

        // Asynchronous clear mid-scan
        #2;
        CLR = 1'b1;
        model_reset();
        #1;
        check("clr_an", {4'h0, an}, 8'h0F);
        check("clr_seg", {1'b0, seg}, 8'h00);
        check("clr_dp", {7'h0, dp}, 8'h00);
        check("clr_fd", {7'h0, frame_done}, 8'h00);
        steps(2);
        CLR = 1'b0;
        set_in(4'd0, 4'd0, 4'd4, 4'd2);
        step();
        check("restart_an", {4'h0, an}, 8'h0E);
        check("restart_seg", {1'b0, seg}, 8'h3F);

        // Leading zeros for 0042
        steps(16);
        check("lz0_seg", {1'b0, seg}, 8'h5B);
        steps(4);
        check("lz1_seg", {1'b0, seg}, 8'h66);
        steps(4);
        check("lz2_an", {4'h0, an}, 8'h0B);
        check("lz2_seg", {1'b0, seg}, LZ_SEG);
        steps(4);
        check("lz3_an", {4'h0, an}, 8'h07);
        check("lz3_seg", {1'b0, seg}, LZ_SEG);
        check("lz3_dp_cleared", {7'h0, dp}, 8'h00);
        steps(8);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
